// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the FSM state encoding, the default width and the operand magnitude helper.
package div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN,
        DONE
    } div_state_t;

    // Magnitude of a two's-complement value when sgn is set; raw value otherwise.
    // -2^31 maps onto itself, which reads correctly as unsigned 2^31.
    function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] x, input logic sgn);
        return (sgn && x[DIV_W-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract the divisor.
// Purely combinational; the caller registers rem_next and collects qbit.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The extra bit keeps the shifted partial remainder exact before the compare.
    assign shifted  = {rem, dbit};
    assign diff     = shifted - {1'b0, divisor};
    assign qbit     = (shifted >= {1'b0, divisor});
    // Whichever branch is taken, the result is below the divisor and fits in WIDTH bits.
    assign rem_next = WIDTH'(qbit ? diff : shifted);

endmodule

// File: rtl/div.sv
// Sequential WIDTH-bit divider with DIV/DIVU semantics; one quotient bit per clock.
// Operands are captured on the first edge after reset release; a new division needs a new reset.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signdiv,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_t       state_reg;
    div_state_t       state_next;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             negq_reg;
    logic             negr_reg;
    logic             divz_reg;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;
    logic             last_iter;

    assign last_iter = (count_reg == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .dbit     (dvd_reg[WIDTH-1]),
        .divisor  (dvs_reg),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = RUN;
            RUN:     state_next = last_iter ? FIN : RUN;
            FIN:     state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // dvd_reg doubles as the quotient: dividend bits shift out the top as quotient bits enter below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
            rem_reg   <= '0;
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            negq_reg  <= 1'b0;
            negr_reg  <= 1'b0;
            divz_reg  <= 1'b0;
            q         <= '0;
            r         <= '0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    dvd_reg   <= abs_val(a, signdiv);
                    dvs_reg   <= abs_val(b, signdiv);
                    negq_reg  <= signdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
                    negr_reg  <= signdiv & a[WIDTH-1];
                    divz_reg  <= (b == '0);
                    rem_reg   <= '0;
                    count_reg <= '0;
                end
                RUN: begin
                    rem_reg   <= step_rem;
                    dvd_reg   <= {dvd_reg[WIDTH-2:0], step_qbit};
                    count_reg <= count_reg + 1'b1;
                end
                FIN: begin
                    // Divide by zero yields all ones regardless of sign; r = -|a| already equals a.
                    q    <= divz_reg ? '1 : (negq_reg ? -dvd_reg : dvd_reg);
                    r    <= negr_reg ? -rem_reg : rem_reg;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: scoreboard of expected q/r, latency and reset behaviour checks.
module tb_div;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        signdiv;
    logic [31:0] q;
    logic [31:0] r;
    logic        done;

    typedef struct {
        string       tag;
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .signdiv (signdiv),
        .q       (q),
        .r       (r),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reset, apply operands, release, then watch up to 40 edges for done.
    // chg_edge > 0 scrambles the operands after that edge to show they are ignored.
    task automatic run_case(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                            input logic ts, input logic [31:0] eq, input logic [31:0] er,
                            input int chg_edge);
        exp_t e;
        int   done_edge;
        bit   early_ok;
        rst = 1'b0;
        @(negedge clk);
        a = ta;
        b = tbv;
        signdiv = ts;
        e.tag = tag;
        e.q = eq;
        e.r = er;
        sb.push_back(e);
        @(negedge clk);
        check({tag, " reset q"}, q, 32'h0);
        check({tag, " reset r"}, r, 32'h0);
        check({tag, " reset done"}, {31'h0, done}, 32'h0);
        rst = 1'b1;
        done_edge = 0;
        early_ok = 1'b1;
        for (int edge_n = 1; edge_n <= 40 && done_edge == 0; edge_n++) begin
            @(posedge clk);
            #1;
            if (edge_n == chg_edge) begin
                a = ~a;
                b = b + 32'd5;
                signdiv = ~signdiv;
            end
            if (done) done_edge = edge_n;
            else if (q !== 32'h0 || r !== 32'h0) early_ok = 1'b0;
        end
        check({tag, " done edge"}, 32'(done_edge), 32'd34);
        check({tag, " zero before done"}, {31'h0, early_ok}, 32'h1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " q"}, q, e.q);
            check({e.tag, " r"}, r, e.r);
        end
        $display("case %s a=%h b=%h s=%b -> q=%h r=%h done_edge=%0d", tag, ta, tbv, ts, q, r, done_edge);
    endtask

    initial begin
        rst = 1'b0;
        a = 32'h0;
        b = 32'h0;
        signdiv = 1'b0;
        repeat (2) @(negedge clk);

        run_case("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 0);

        // Result must hold in DONE while operands wander.
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom;
            signdiv = ~signdiv;
            @(posedge clk);
            #1;
        end
        check("hold q", q, 32'd14);
        check("hold r", r, 32'd2);
        check("hold done", {31'h0, done}, 32'h1);
        $display("hold q=%h r=%h done=%b", q, r, done);

        // Reset between edges must clear outputs without waiting for a clock.
        #3 rst = 1'b0;
        #1;
        check("async reset q", q, 32'h0);
        check("async reset r", r, 32'h0);
        check("async reset done", {31'h0, done}, 32'h0);
        $display("async reset q=%h r=%h done=%b", q, r, done);

        run_case("div_m7_2",     32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_case("div_7_m2",     32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         0);
        run_case("divu_ffff_2",  32'hFFFF_FFFF, 32'd2,         1'b0, 32'h7FFF_FFFF, 32'd1,         0);
        run_case("div_m1_2",     32'hFFFF_FFFF, 32'd2,         1'b1, 32'h0,         32'hFFFF_FFFF, 0);
        run_case("divu_by_zero", 32'd12345,     32'd0,         1'b0, 32'hFFFF_FFFF, 32'd12345,     0);
        run_case("div_by_zero",  32'd12345,     32'd0,         1'b1, 32'hFFFF_FFFF, 32'd12345,     0);
        run_case("div_neg_by_0", 32'hFFFF_FFF9, 32'd0,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 0);
        run_case("div_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0,         0);
        run_case("divu_change",  32'd1000,      32'd3,         1'b0, 32'd333,       32'd1,         5);

        // Abort a division partway through RUN.
        rst = 1'b0;
        @(negedge clk);
        a = 32'd5000;
        b = 32'd9;
        signdiv = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort q", q, 32'h0);
        check("abort r", r, 32'h0);
        check("abort done", {31'h0, done}, 32'h0);
        $display("abort q=%h r=%h done=%b", q, r, done);

        run_case("div_m100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);

        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
